// File: rtl/wallace_mul_pkg.sv
// ============================================================================
// wallace_mul_pkg : shared constants, stage bundle and tree-sizing helpers
// Rev 1.0
// ============================================================================
`default_nettype none

package wallace_mul_pkg;

    localparam int PIPE_STAGES = 3;
    localparam int STG_PP      = 0;
    localparam int STG_RED     = 1;
    localparam int STG_CPA     = 2;

    typedef struct packed {
        logic valid;
        logic sgn;
    } stage_ctl_t;

    function automatic int prod_width(input int w);
        return 2 * w;
    endfunction

    // Rows left after one carry-save layer: every full triple becomes two rows.
    function automatic int csa_rows_after(input int n);
        return (n / 3) * 2 + (n % 3);
    endfunction

    function automatic int csa_rows_at(input int n, input int lvl);
        int r;
        r = n;
        for (int l = 0; l < lvl; l++) r = csa_rows_after(r);
        return r;
    endfunction

    function automatic int csa_levels(input int n);
        int r;
        int l;
        r = n;
        l = 0;
        while (r > 2) begin
            r = csa_rows_after(r);
            l++;
        end
        return l;
    endfunction

endpackage

`default_nettype wire

// File: rtl/wallace_mul_pipe_reduce.sv
// ============================================================================
// wallace_reduce : combinational Wallace tree, WIDTH rows down to two rows
// Rev 1.0
// ============================================================================
`default_nettype none

module wallace_reduce
    import wallace_mul_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0][2*WIDTH-1:0] pp_rows,
    output logic [2*WIDTH-1:0]            sum_row,
    output logic [2*WIDTH-1:0]            carry_row
);

    localparam int PW     = prod_width(WIDTH);
    localparam int LEVELS = csa_levels(WIDTH);

    logic [PW-1:0] w_lvl [0:LEVELS][0:WIDTH-1];

    generate
        for (genvar r = 0; r < WIDTH; r++) begin : g_in
            assign w_lvl[0][r] = pp_rows[r];
        end

        for (genvar l = 0; l < LEVELS; l++) begin : g_level
            localparam int N = csa_rows_at(WIDTH, l);
            localparam int G = N / 3;
            for (genvar k = 0; k < WIDTH; k++) begin : g_row
                if (k < 2 * G) begin : g_csa
                    localparam int B = 3 * (k / 2);
                    if (k % 2 == 0) begin : g_sum
                        assign w_lvl[l+1][k] = w_lvl[l][B] ^ w_lvl[l][B+1] ^ w_lvl[l][B+2];
                    end else begin : g_carry
                        assign w_lvl[l+1][k] = ((w_lvl[l][B]   & w_lvl[l][B+1]) |
                                                (w_lvl[l][B]   & w_lvl[l][B+2]) |
                                                (w_lvl[l][B+1] & w_lvl[l][B+2])) << 1;
                    end
                end else if ((N % 3 == 2) && (k == 2 * G)) begin : g_ha_sum
                    // A leftover pair goes through a 2:2 compressor.
                    assign w_lvl[l+1][k] = w_lvl[l][3*G] ^ w_lvl[l][3*G+1];
                end else if ((N % 3 == 2) && (k == 2 * G + 1)) begin : g_ha_carry
                    assign w_lvl[l+1][k] = (w_lvl[l][3*G] & w_lvl[l][3*G+1]) << 1;
                end else if (k < 2 * G + N % 3) begin : g_pass
                    assign w_lvl[l+1][k] = w_lvl[l][3*G + k - 2*G];
                end else begin : g_zero
                    assign w_lvl[l+1][k] = '0;
                end
            end
        end
    endgenerate

    assign sum_row   = w_lvl[LEVELS][0];
    assign carry_row = w_lvl[LEVELS][1];

endmodule

`default_nettype wire

// File: rtl/wallace_mul_pipe.sv
// ============================================================================
// wallace_mul_pipe : pipelined Wallace multiplier, valid/ready, signed/unsigned
// Signed (Baugh-Wooley) support compiled only with WALLACE_MUL_SIGNED_EN. Rev 1.0
// ============================================================================
`default_nettype none

module wallace_mul_pipe
    import wallace_mul_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   multiplicand_a,
    input  logic [WIDTH-1:0]   multiplier_b,
    input  logic               signed_mode,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] product
);

    localparam int PW = prod_width(WIDTH);

    logic                         w_advance;
    stage_ctl_t                   w_in_ctl;
    logic [PIPE_STAGES-1:0]       r_valid;
    logic                         r_out_valid;
    logic [WIDTH-1:0]             r_a;
    logic [WIDTH-1:0]             r_b;
    logic [WIDTH-1:0][PW-1:0]     w_pp_rows;
    logic [WIDTH-1:0][PW-1:0]     r_pp_rows;
    logic [PW-1:0]                w_red_sum;
    logic [PW-1:0]                w_red_carry;
    logic [PW-1:0]                r_red_sum;
    logic [PW-1:0]                r_red_carry;
    logic [PW-1:0]                r_product;

    assign w_advance      = !r_out_valid || out_ready;
    assign in_ready       = w_advance;
    assign out_valid      = r_out_valid;
    assign product        = r_product;
    assign w_in_ctl.valid = in_valid;

`ifdef WALLACE_MUL_SIGNED_EN
    logic r_pp_sgn;

    assign w_in_ctl.sgn = signed_mode;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_pp_sgn <= 1'b0;
        else if (w_advance && w_in_ctl.valid)
            r_pp_sgn <= w_in_ctl.sgn;
    end
`else
    logic w_unused_sgn;

    assign w_in_ctl.sgn = 1'b0;
    assign w_unused_sgn = signed_mode | w_in_ctl.sgn;
`endif

    always_comb begin
        w_pp_rows = '0;
        for (int i = 0; i < WIDTH; i++)
            for (int j = 0; j < WIDTH; j++)
                w_pp_rows[i][i+j] = r_a[j] & r_b[i];
`ifdef WALLACE_MUL_SIGNED_EN
        // Baugh-Wooley: the two constant ones sit in bit slots no row uses.
        if (r_pp_sgn) begin
            for (int i = 0; i < WIDTH - 1; i++) begin
                w_pp_rows[i][i+WIDTH-1]       = ~(r_a[WIDTH-1] & r_b[i]);
                w_pp_rows[WIDTH-1][i+WIDTH-1] = ~(r_a[i] & r_b[WIDTH-1]);
            end
            w_pp_rows[0][WIDTH]       = 1'b1;
            w_pp_rows[WIDTH-1][PW-1]  = 1'b1;
        end
`endif
    end

    wallace_reduce #(.WIDTH(WIDTH)) u_reduce (
        .pp_rows   (r_pp_rows),
        .sum_row   (w_red_sum),
        .carry_row (w_red_carry)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid     <= '0;
            r_out_valid <= 1'b0;
            r_a         <= '0;
            r_b         <= '0;
            r_pp_rows   <= '0;
            r_red_sum   <= '0;
            r_red_carry <= '0;
            r_product   <= '0;
        end else if (w_advance) begin
            r_valid[STG_PP]  <= w_in_ctl.valid;
            r_valid[STG_RED] <= r_valid[STG_PP];
            r_valid[STG_CPA] <= r_valid[STG_RED];
            r_out_valid      <= r_valid[STG_CPA];
            if (w_in_ctl.valid) begin
                r_a <= multiplicand_a;
                r_b <= multiplier_b;
            end
            if (r_valid[STG_PP])
                r_pp_rows <= w_pp_rows;
            if (r_valid[STG_RED]) begin
                r_red_sum   <= w_red_sum;
                r_red_carry <= w_red_carry;
            end
            if (r_valid[STG_CPA])
                r_product <= r_red_sum + r_red_carry;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_wallace_mul_pipe.sv
// Scoreboard bench for wallace_mul_pipe: WIDTH=8 stream/stall/reset tests plus a WIDTH=16 instance.
`default_nettype none

module tb_wallace_mul_pipe;

`ifdef WALLACE_MUL_SIGNED_EN
    localparam bit SIGNED_EN = 1'b1;
`else
    localparam bit SIGNED_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid8 = 1'b0, in_ready8, sm8 = 1'b0, out_valid8, out_ready8 = 1'b1;
    logic [7:0]  a8 = '0, b8 = '0;
    logic [15:0] product8;
    logic        in_valid16 = 1'b0, in_ready16, sm16 = 1'b0, out_valid16;
    logic [15:0] a16 = '0, b16 = '0;
    logic [31:0] product16;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [15:0] exp_q [$];

    always #5 clk = ~clk;

    wallace_mul_pipe #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8),
        .multiplicand_a(a8), .multiplier_b(b8), .signed_mode(sm8),
        .out_valid(out_valid8), .out_ready(out_ready8), .product(product8)
    );

    wallace_mul_pipe #(.WIDTH(16)) u_dut16 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid16), .in_ready(in_ready16),
        .multiplicand_a(a16), .multiplier_b(b16), .signed_mode(sm16),
        .out_valid(out_valid16), .out_ready(1'b1), .product(product16)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [15:0] a, input logic [15:0] b,
                                          input logic s, input int w);
        longint sa, sb, p;
        sa = longint'(a);
        sb = longint'(b);
        if (s && SIGNED_EN) begin
            if (a[w-1]) sa = sa - (longint'(1) << w);
            if (b[w-1]) sb = sb - (longint'(1) << w);
        end
        p = sa * sb;
        return (w == 8) ? {16'h0000, p[15:0]} : p[31:0];
    endfunction

    // Scoreboard: every product leaving the 8-bit pipe is checked in order.
    always @(negedge clk) begin
        if (rst_n && out_valid8 && out_ready8) begin
            if (exp_q.size() == 0)
                check("sb_underflow", 32'(exp_q.size()), 32'd1);
            else
                check("sb_product", {16'h0, product8}, {16'h0, exp_q.pop_front()});
        end
    end

    task automatic send8(input logic [7:0] a, input logic [7:0] b, input logic s);
        bit          done;
        bit          acc;
        logic [31:0] e;
        done = 1'b0;
        in_valid8 = 1'b1; a8 = a; b8 = b; sm8 = s;
        for (int t = 0; t < 200 && !done; t++) begin
            @(negedge clk);
            acc = in_ready8;
            @(posedge clk);
            #1;
            if (acc) begin
                e = model({8'h00, a}, {8'h00, b}, s, 8);
                exp_q.push_back(e[15:0]);
                done = 1'b1;
            end
        end
        if (!done) check("send_timeout", 32'(done), 32'd1);
        in_valid8 = 1'b0;
    endtask

    task automatic drain(input string tag);
        for (int t = 0; t < 100 && exp_q.size() != 0; t++) @(negedge clk);
        check(tag, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic latency_probe(input string tag);
        int k;
        k = 0;
        for (int t = 1; t <= 10 && k == 0; t++) begin
            @(negedge clk);
            if (out_valid8) k = t;
        end
        check(tag, 32'(k), 32'd4);
    endtask

    task automatic run16(input string tag, input logic [15:0] a, input logic [15:0] b, input logic s);
        int got_it;
        @(posedge clk); #1;
        in_valid16 = 1'b1; a16 = a; b16 = b; sm16 = s;
        @(posedge clk); #1;
        in_valid16 = 1'b0;
        got_it = 0;
        for (int t = 0; t < 10 && got_it == 0; t++) begin
            @(negedge clk);
            if (out_valid16) got_it = 1;
        end
        check({tag, "_valid"}, 32'(got_it), 32'd1);
        check(tag, product16, model(a, b, s, 16));
    endtask

    initial begin
        #1;
        check("rst_out_valid", {31'h0, out_valid8}, 32'd0);
        check("rst_product",   {16'h0, product8},  32'd0);
        check("rst_in_ready",  {31'h0, in_ready8}, 32'd1);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // First-result latency and corner operands
        @(posedge clk); #1;
        send8(8'hFF, 8'hFF, 1'b0);
        latency_probe("latency_ff_ff");
        drain("drain_latency");
        @(posedge clk); #1;
        send8(8'h80, 8'h80, 1'b0);
        send8(8'h00, 8'h5A, 1'b0);
        send8(8'hFF, 8'hFF, 1'b1);
        send8(8'h80, 8'h80, 1'b1);
        send8(8'h80, 8'h7F, 1'b1);
        send8(8'hFE, 8'h03, 1'b1);
        drain("drain_corners");

        // Back-to-back mixed-mode stream: 16 results on consecutive cycles
        @(posedge clk); #1;
        fork
            begin
                for (int i = 0; i < 16; i++)
                    send8(8'($urandom), 8'($urandom), 1'(i % 2));
            end
            begin
                for (int t = 0; t < 50 && !out_valid8; t++) @(negedge clk);
                for (int i = 0; i < 16; i++) begin
                    if (i > 0) @(negedge clk);
                    check("stream_valid", {31'h0, out_valid8}, 32'd1);
                end
            end
        join
        drain("drain_stream");

        // Backpressure: out_ready low for 5 cycles while input keeps offering
        @(posedge clk); #1;
        fork
            begin
                for (int i = 0; i < 10; i++)
                    send8(8'($urandom), 8'($urandom), 1'(i % 3 == 0));
            end
            begin
                logic [15:0] held;
                repeat (4) @(posedge clk);
                #1 out_ready8 = 1'b0;
                @(negedge clk);
                held = product8;
                for (int i = 0; i < 5; i++) begin
                    if (i > 0) @(negedge clk);
                    check("stall_in_ready",  {31'h0, in_ready8},  32'd0);
                    check("stall_out_valid", {31'h0, out_valid8}, 32'd1);
                    check("stall_product",   {16'h0, product8},   {16'h0, held});
                end
                @(posedge clk);
                #1 out_ready8 = 1'b1;
            end
        join
        drain("drain_backpressure");

        // Reset with three operations in flight
        @(posedge clk); #1;
        send8(8'h12, 8'h34, 1'b0);
        send8(8'hC3, 8'h3C, 1'b1);
        send8(8'h77, 8'h99, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_out_valid", {31'h0, out_valid8}, 32'd0);
        check("midrst_product",   {16'h0, product8},   32'd0);
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        check("post_rst_idle", {31'h0, out_valid8}, 32'd0);
        @(posedge clk); #1;
        send8(8'h5A, 8'hA5, 1'b0);
        latency_probe("latency_post_rst");
        drain("drain_post_rst");

        // WIDTH=16 instance
        check("w16_in_ready", {31'h0, in_ready16}, 32'd1);
        run16("w16_ffff_ffff_u", 16'hFFFF, 16'hFFFF, 1'b0);
        run16("w16_8000_8000_s", 16'h8000, 16'h8000, 1'b1);
        run16("w16_1234_fedc_s", 16'h1234, 16'hFEDC, 1'b1);
        run16("w16_7fff_8000_s", 16'h7FFF, 16'h8000, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/wallace_mul_pipe.md
# wallace_mul_pipe

Parametrised, pipelined Wallace-tree multiplier with a valid/ready handshake and per-operation signed/unsigned mode. It is the successor to the combinational 8-bit unsigned Wallace-tree multiplier. It generalises operand width, and registers partial-product generation, tree reduction and final carry-propagate addition into three stages. It sits between operand sources and any consumer that may apply backpressure.

## Interface
- `WIDTH`, default 8: operand width in bits, ≥ 4. The product is 2*WIDTH bits.
- `clk` in 1: single clock, all state on rising edge.
- `rst_n` in 1: reset, asynchronous and active-low.
- `in_valid` in 1: the operand pair and mode are valid.
- `in_ready` out 1: the block accepts an operand pair this cycle.
- `multiplicand_a` in WIDTH: operand A.
- `multiplier_b` in WIDTH: operand B.
- `signed_mode` in 1: 1 = two's-complement operands, 0 = unsigned. Sampled with the operands.
- `out_valid` out 1: `product` is valid.
- `out_ready` in 1: the consumer accepts the product.
- `product` out 2*WIDTH: the result.

## Operation
- Transfer in: occurs when `in_valid && in_ready` at a rising edge.
- Transfer out: occurs when `out_valid && out_ready` at a rising edge.
- Stage 1 (PP): forms WIDTH partial-product rows.
  - Signed mode uses Baugh-Wooley: invert the MSB-row and MSB-column terms, add 1 at bit WIDTH and 1 at bit 2*WIDTH-1.
  - Unsigned mode uses plain AND rows.
- Stage 2 (RED): Wallace reduction with 3:2 and 2:2 compressors until two rows of 2*WIDTH bits remain. Both rows are registered.
- Stage 3 (CPA): adds the two rows and truncates to 2*WIDTH bits, which is the exact result in both modes. The sum is registered to `product`.
- Each stage holds a valid bit. Define `advance = !out_valid || out_ready`.
  - All three stages shift together when `advance` is 1.
  - The whole pipe freezes when `advance` is 0.
- `in_ready = advance`, a combinational path from `out_ready`.
- Bubbles are not collapsed. An empty stage moves through the pipe like data.
- Stage data registers load only when the incoming valid bit is 1. Idle cycles leave `product` unchanged.

## Timing
- Reset (async assert): clears all stage valid bits and `out_valid`, and sets `product` to 0. `in_ready` is then 1.
- Latency: a transfer in at edge n gives `out_valid` = 1 with its product after edge n+3, provided no stall occurs.
- Throughput: one operation per cycle while `out_ready` stays 1.
- Stall: with `out_valid` = 1 and `out_ready` = 0, `product` and `out_valid` hold stable and `in_ready` = 0. No operand is lost or duplicated.
- Simultaneous transfer out and transfer in on the same edge is legal. The pipe shifts by one.
- Reset mid-operation: every in-flight operation is discarded. The first post-reset result appears 3 cycles after the first post-reset transfer in.
- `signed_mode` is captured per operation. Mixed modes back-to-back are legal.

## Configuration
- `WALLACE_MUL_SIGNED_EN`
  - Defined: signed mode works as specified above.
  - Undefined: `signed_mode` is ignored, every operation is unsigned, and the Baugh-Wooley correction logic is not compiled.

## Structure
- Shared package `wallace_mul_pkg`:
  - `PIPE_STAGES` = 3.
  - Stage-index constants.
  - A typedef for the stage valid/mode bundle.
  - Function `prod_width(w)` returning 2*w.
- Sub-module `wallace_reduce`: a combinational, WIDTH-parametrised reduction tree. It maps partial-product rows to two 2*WIDTH rows and is instantiated once in stage 2.

## Test plan
- Unsigned, WIDTH=8, `out_ready` held 1:
  - FF*FF -> FE01, exactly 3 cycles after the transfer in.
  - 80*80 -> 4000.
  - 00*5A -> 0000.
- Signed, WIDTH=8:
  - FF*FF (-1*-1) -> 0001.
  - 80*80 -> 4000.
  - 80*7F -> C080.
  - FE*03 -> FFFA.
- Back-to-back stream of 16 pairs alternating signed and unsigned, with `out_ready` held 1 -> 16 correct results on 16 consecutive cycles, in order.
- Backpressure: drop `out_ready` for 5 cycles while `in_valid` stays 1 -> `in_ready` is 0 and `product` is stable throughout. After `out_ready` rises, no result is lost or duplicated.
- Assert `rst_n` low with 3 operations in flight -> `out_valid` is 0 and `product` is 0000 immediately. No stale result appears after release.
- WIDTH=16:
  - Unsigned FFFF*FFFF -> FFFE0001.
  - Signed 8000*8000 -> 40000000.
  - Build with `WALLACE_MUL_SIGNED_EN` undefined: signed_mode=1 with FF*FF gives FE01.
